credit_link_tx: RTL and testbench
=================================

# credit_link_tx

Upstream link-side sender that feeds a router input `circular_buffer` over a point-to-point link with credit-based flow control. It accepts flits from the local source through a valid/ready handshake. It forwards each flit as a registered one-cycle write pulse into the downstream buffer. It tracks the downstream buffer's free slots with a credit counter, so the buffer never sees a write while full. A packet-framing FSM checks head/body/tail ordering and raises a sticky error on protocol or credit violations.

## Interface
- `BUFFER_SIZE`, default 8: depth of the downstream buffer; initial and maximum credit count.
- `FLIT_SIZE`, default 8: flit width in bits, minimum 3. `data_i[FLIT_SIZE-1:FLIT_SIZE-2]` is the flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion (0) clears state immediately, independent of `clk`.
- `valid_i`  in  1  source presents a flit.
- `data_i`  in  FLIT_SIZE  flit from the source.
- `ready_o`  out  1  block can accept a flit this cycle.
- `credit_i`  in  1  one-cycle pulse meaning one downstream slot has been freed (one downstream read).
- `write_o`  out  1  write strobe to downstream `write_i`.
- `data_o`  out  FLIT_SIZE  flit to downstream `data_i`.
- `credits_o`  out  $clog2(BUFFER_SIZE+1)  current credit count.
- `in_packet_o`  out  1  FSM is in state IN_PACKET.
- `error_o`  out  1  sticky violation flag.

## Operation
- Send condition: `send = valid_i && ready_o`.
- Ready: `ready_o = (credits_o != 0)`, a combinational function of registered state only. A `credit_i` arriving in the same cycle does not raise `ready_o`.
- Credit update per cycle: `credits_next = credits + credit_i - send`.
  - Simultaneous send and credit: count unchanged.
  - Credit at count BUFFER_SIZE with no send: count saturates at BUFFER_SIZE and `error_o` sets.
  - Underflow is impossible because `send` requires `ready_o`.
- Output register:
  - `write_o <= send`.
  - `data_o <= data_i` when `send`; otherwise `data_o` holds its value.
- Invariant: credits + downstream occupancy + in-flight writes ≤ BUFFER_SIZE. Consequently `write_o` is never asserted while the downstream `is_full_o` is high.
- FSM states are IDLE and IN_PACKET. Transitions happen only on `send`:
  - HEAD: IDLE → IN_PACKET. If already in IN_PACKET, set `error_o` and stay in IN_PACKET.
  - BODY: legal only in IN_PACKET, no state change. In IDLE, set `error_o` and stay in IDLE.
  - TAIL: IN_PACKET → IDLE. In IDLE, set `error_o` and stay in IDLE.
  - HEADTAIL: legal only in IDLE, stays in IDLE. In IN_PACKET, set `error_o` and go to IDLE.
- Illegal flits are still forwarded. The block never drops or reorders flits.
- `error_o` is sticky: it clears only on reset.

## Timing
- Reset values: `credits_o` = BUFFER_SIZE, `ready_o` = 1, `write_o` = 0, `data_o` = 0, `in_packet_o` = 0, `error_o` = 0.
- Latency: a flit accepted at edge N appears on `write_o`/`data_o` during cycle N+1. The downstream buffer captures it at edge N+1.
- Throughput: one flit per cycle while credits > 0.
- A credit received at edge N is visible in `credits_o` and `ready_o` in cycle N+1.
- `in_packet_o` and `error_o` update one cycle after the causing send or credit.
- Reset mid-packet: all state returns to reset values asynchronously. Any partially sent packet is abandoned and its in-flight `write_o` pulse is cancelled. Downstream must be reset together with this block.
- Reset release is synchronous to `clk`. The first send can occur at the first rising edge after `rst` goes high.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release -> `credits_o`=8, `ready_o`=1, `write_o`=0, `error_o`=0. Assert `rst`=0 between edges -> all outputs return to reset values immediately.
- Saturation: `valid_i`=1 for 10 cycles with HEAD, then BODYs, and `credit_i`=0. Expect:
  - exactly 8 `write_o` pulses carrying the 8 flits in order;
  - `credits_o` stepping 8→0;
  - `ready_o`=0 from the 9th cycle;
  - the 9th flit held at the input.
- Credit release at 0: pulse `credit_i` once -> next cycle `credits_o`=1 and `ready_o`=1. The held flit sends, then `credits_o`=0 the following cycle.
- Simultaneous events: at `credits_o`=3, `send` and `credit_i` in the same cycle -> `credits_o` stays 3 and `write_o` pulses once.
- Overflow: at `credits_o`=8, pulse `credit_i` -> `credits_o` stays 8, `error_o`=1 next cycle, and `error_o` remains 1 until reset.
- Framing:
  - HEAD, BODY, TAIL, HEADTAIL -> `in_packet_o` is 1 after HEAD and 0 after TAIL, `error_o`=0;
  - then BODY in IDLE -> `error_o`=1 and the flit still appears on `data_o`;
  - reset asserted after a HEAD -> `in_packet_o`=0.

Source files
------------

// File: rtl/credit_link_tx.sv
`default_nettype none
// ============================================================================
// credit_link_tx : credit-flow-controlled flit sender with packet framing check
// Rev 1.0
// ============================================================================
module credit_link_tx #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_i,
  input  logic [FLIT_SIZE-1:0]             data_i,
  output logic                             ready_o,
  input  logic                             credit_i,
  output logic                             write_o,
  output logic [FLIT_SIZE-1:0]             data_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] credits_o,
  output logic                             in_packet_o,
  output logic                             error_o
);

  localparam int            CW          = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] MAX_CREDITS = CW'(BUFFER_SIZE);
  localparam logic [1:0]    FT_HEAD     = 2'b00;
  localparam logic [1:0]    FT_BODY     = 2'b01;
  localparam logic [1:0]    FT_TAIL     = 2'b10;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] credits, credits_next;
  logic          send;
  logic          overflow;
  logic          frame_err;
  logic          error;
  logic [1:0]    flit_type;

  // Ready depends on registered credits only, so a same-cycle credit cannot enable a send.
  assign ready_o   = (credits != '0);
  assign send      = valid_i && ready_o;
  assign flit_type = data_i[FLIT_SIZE-1 -: 2];

  always_comb begin
    credits_next = credits;
    overflow     = 1'b0;
    case ({credit_i, send})
      2'b10: begin
        if (credits == MAX_CREDITS) begin
          overflow = 1'b1;
        end else begin
          credits_next = credits + CW'(1);
        end
      end
      2'b01:   credits_next = credits - CW'(1);
      default: credits_next = credits;
    endcase
  end

  always_comb begin
    state_next = state;
    frame_err  = 1'b0;
    if (send) begin
      case (flit_type)
        FT_HEAD: begin
          if (state == IDLE) state_next = IN_PACKET;
          else               frame_err  = 1'b1;
        end
        FT_BODY: begin
          if (state == IDLE) frame_err = 1'b1;
        end
        FT_TAIL: begin
          if (state == IN_PACKET) state_next = IDLE;
          else                    frame_err  = 1'b1;
        end
        default: begin
          state_next = IDLE;
          if (state == IN_PACKET) frame_err = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      credits <= MAX_CREDITS;
      error   <= 1'b0;
      write_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state   <= state_next;
      credits <= credits_next;
      error   <= error | overflow | frame_err;
      write_o <= send;
      if (send) data_o <= data_i;
    end
  end

  assign credits_o   = credits;
  assign in_packet_o = (state == IN_PACKET);
  assign error_o     = error;

endmodule
`default_nettype wire

// File: tb/tb_credit_link_tx.sv
`default_nettype none
// ============================================================================
// tb_credit_link_tx : directed self-checking bench for credit_link_tx
// Rev 1.0
// ============================================================================
module tb_credit_link_tx;

  localparam int BUFFER_SIZE = 8;
  localparam int FLIT_SIZE   = 8;
  localparam int CW          = $clog2(BUFFER_SIZE + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 ready_o;
  logic                 credit_i;
  logic                 write_o;
  logic [FLIT_SIZE-1:0] data_o;
  logic [CW-1:0]        credits_o;
  logic                 in_packet_o;
  logic                 error_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] flits [10];

  credit_link_tx #(
    .BUFFER_SIZE(BUFFER_SIZE),
    .FLIT_SIZE  (FLIT_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .credit_i   (credit_i),
    .write_o    (write_o),
    .data_o     (data_o),
    .credits_o  (credits_o),
    .in_packet_o(in_packet_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] f);
    valid_i = 1'b1;
    data_i  = f;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_credits"}, 32'(credits_o), 32'd8);
    check({tag, "_ready"},   32'(ready_o),   32'd1);
    check({tag, "_write"},   32'(write_o),   32'd0);
    check({tag, "_data"},    32'(data_o),    32'd0);
    check({tag, "_inpkt"},   32'(in_packet_o), 32'd0);
    check({tag, "_error"},   32'(error_o),   32'd0);
  endtask

  initial begin
    int mcred;
    int idx;
    int wp;

    flits[0] = 8'h01;
    for (int i = 1; i < 10; i++) flits[i] = 8'h40 + 8'(i);

    rst = 1'b0; valid_i = 1'b0; data_i = '0; credit_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("rst_rel");

    // Saturation: HEAD then BODYs with no credits returned
    mcred = 8; idx = 0; wp = 0;
    valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      data_i = flits[idx];
      check("sat_ready", 32'(ready_o), (mcred != 0) ? 32'd1 : 32'd0);
      tick();
      wp += int'(write_o);
      if (mcred != 0) begin
        check("sat_write", 32'(write_o), 32'd1);
        check("sat_data",  32'(data_o),  32'(flits[idx]));
        idx++;
        mcred--;
      end else begin
        check("sat_hold_write", 32'(write_o), 32'd0);
      end
      check("sat_credits", 32'(credits_o), 32'(mcred));
    end
    check("sat_pulses",    32'(wp),          32'd8);
    check("sat_data_held", 32'(data_o),      32'(flits[7]));
    check("sat_ready_low", 32'(ready_o),     32'd0);
    check("sat_inpkt",     32'(in_packet_o), 32'd1);
    check("sat_error",     32'(error_o),     32'd0);

    // Credit release at zero: held flit 8 still presented
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    check("rel_credits", 32'(credits_o), 32'd1);
    check("rel_ready",   32'(ready_o),   32'd1);
    check("rel_write",   32'(write_o),   32'd0);
    tick();
    valid_i = 1'b0;
    check("rel_send_write", 32'(write_o),   32'd1);
    check("rel_send_data",  32'(data_o),    32'(flits[8]));
    check("rel_credits0",   32'(credits_o), 32'd0);

    // Simultaneous send and credit at 3
    credit_i = 1'b1;
    repeat (3) tick();
    credit_i = 1'b0;
    check("sim_pre", 32'(credits_o), 32'd3);
    valid_i = 1'b1; data_i = flits[9]; credit_i = 1'b1;
    tick();
    valid_i = 1'b0; credit_i = 1'b0;
    check("sim_credits", 32'(credits_o), 32'd3);
    check("sim_write",   32'(write_o),   32'd1);
    check("sim_data",    32'(data_o),    32'(flits[9]));
    tick();
    check("sim_write_once", 32'(write_o),   32'd0);
    check("sim_credits2",   32'(credits_o), 32'd3);

    // Overflow at full credit count
    credit_i = 1'b1;
    repeat (5) tick();
    credit_i = 1'b0;
    check("ovf_full",   32'(credits_o), 32'd8);
    check("ovf_noerr",  32'(error_o),   32'd0);
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    check("ovf_credits", 32'(credits_o), 32'd8);
    check("ovf_error",   32'(error_o),   32'd1);
    repeat (3) tick();
    check("ovf_sticky",  32'(error_o),   32'd1);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Legal framing
    send_one(8'h01);
    check("frm_head_inpkt", 32'(in_packet_o), 32'd1);
    send_one(8'h42);
    check("frm_body_inpkt", 32'(in_packet_o), 32'd1);
    send_one(8'h83);
    check("frm_tail_inpkt", 32'(in_packet_o), 32'd0);
    send_one(8'hC4);
    check("frm_ht_inpkt",   32'(in_packet_o), 32'd0);
    check("frm_ht_data",    32'(data_o),      32'hC4);
    check("frm_noerr",      32'(error_o),     32'd0);
    check("frm_credits",    32'(credits_o),   32'd4);

    // BODY in IDLE: flagged but still forwarded
    send_one(8'h45);
    check("bad_body_write", 32'(write_o),     32'd1);
    check("bad_body_data",  32'(data_o),      32'h45);
    check("bad_body_error", 32'(error_o),     32'd1);
    check("bad_body_inpkt", 32'(in_packet_o), 32'd0);

    // Reset after a HEAD abandons the packet and cancels the pending write
    send_one(8'h06);
    check("rhead_inpkt", 32'(in_packet_o), 32'd1);
    check("rhead_write", 32'(write_o),     32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("rhead_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_inpkt", 32'(in_packet_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
